// File: rtl/brlite_svc_rx_queue_pkg.sv
// DMNIPkg: BrLite service-packet types shared by the router interface and the NI service queue.
package DMNIPkg;

    localparam int unsigned BRLITE_SVC_DEPTH = 8;

    typedef enum logic [1:0] {
        BR_SVC_ALL = 2'd0,
        BR_SVC_TGT = 2'd1,
        BR_SVC_MON = 2'd2
    } brlite_service_t;

    typedef struct packed {
        brlite_service_t service;
        logic [7:0]      ksvc;
        logic [15:0]     seq_source;
        logic [15:0]     target;
        logic [15:0]     producer;
        logic [31:0]     payload;
    } brlite_in_t;

    typedef struct packed {
        logic [7:0]  ksvc;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_svc_t;

    function automatic brlite_svc_t brlite_to_svc(input brlite_in_t pkt);
        brlite_svc_t svc;
        svc.ksvc       = pkt.ksvc;
        svc.seq_source = pkt.seq_source;
        svc.producer   = pkt.producer;
        svc.payload    = pkt.payload;
        return svc;
    endfunction

endpackage

// File: rtl/brlite_svc_rx_queue_fifo.sv
// brlite_svc_fifo: DEPTH-entry service FIFO with wrapping pointers and an extra-bit occupancy count.
module brlite_svc_fifo
    import DMNIPkg::*;
#(
    parameter int unsigned DEPTH = BRLITE_SVC_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_push,
    input  brlite_svc_t                i_data,
    input  logic                       i_pop,
    output brlite_svc_t                o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int unsigned       PW       = $clog2(DEPTH);
    localparam logic [PW:0]       FULL_CNT = (PW+1)'(DEPTH);

    brlite_svc_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    // Fullness comes from the registered count, so a same-cycle pop never frees room for a push.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/brlite_svc_rx_queue.sv
// brlite_svc_rx_queue: filters BrLite service packets for this PE and queues them for the NI.
// Optional BRLITE_SVC_DROP_EN: ack-and-drop eligible packets when full, with a saturating drop counter.
module brlite_svc_rx_queue
    import DMNIPkg::*;
#(
    parameter int unsigned DEPTH   = BRLITE_SVC_DEPTH,
    parameter logic [15:0] ADDRESS = 16'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        br_rx_i,
    output logic        br_ack_o,
    input  brlite_in_t  br_data_i,
    output logic        br_svc_rx_o,
    input  logic        br_svc_ack_i,
    output brlite_svc_t br_svc_data_o
`ifdef BRLITE_SVC_DROP_EN
    ,
    output logic [15:0] br_svc_drop_cnt_o
`endif
);

    logic                    r_ack;
    logic                    w_eligible;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_full;
    logic [$clog2(DEPTH):0]  w_count;

    assign w_eligible = (br_data_i.service == BR_SVC_ALL) ||
                        ((br_data_i.service == BR_SVC_TGT) && (br_data_i.target == ADDRESS));

`ifdef BRLITE_SVC_DROP_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_accept = br_rx_i & ~r_ack;
    assign w_push   = w_accept & w_eligible & ~w_full;
    assign w_drop   = w_accept & w_eligible & w_full;
    assign br_svc_drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
`else
    // Discarded packets are always accepted; eligible ones wait for room.
    assign w_accept = br_rx_i & ~r_ack & (~w_eligible | ~w_full);
    assign w_push   = w_accept & w_eligible;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_accept;
        end
    end

    brlite_svc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (brlite_to_svc(br_data_i)),
        .i_pop   (br_svc_ack_i),
        .o_data  (br_svc_data_o),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign br_ack_o    = r_ack;
    assign br_svc_rx_o = (w_count != '0);

endmodule

// File: tb/tb_brlite_svc_rx_queue.sv
// Bench for brlite_svc_rx_queue: directed scenarios plus a randomized router/NI run against a queue model.
module tb_brlite_svc_rx_queue;
    import DMNIPkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] ADDR  = 16'h0000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        br_rx   = 1'b0;
    logic        br_ack;
    brlite_in_t  br_data = '0;
    logic        svc_rx;
    logic        svc_ack = 1'b0;
    brlite_svc_t svc_data;
`ifdef BRLITE_SVC_DROP_EN
    logic [15:0] drop_cnt;
`endif

    brlite_svc_rx_queue #(
        .DEPTH   (DEPTH),
        .ADDRESS (ADDR)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .br_rx_i       (br_rx),
        .br_ack_o      (br_ack),
        .br_data_i     (br_data),
        .br_svc_rx_o   (svc_rx),
        .br_svc_ack_i  (svc_ack),
        .br_svc_data_o (svc_data)
`ifdef BRLITE_SVC_DROP_EN
        ,
        .br_svc_drop_cnt_o (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    brlite_svc_t exp_q[$];
    bit          exp_ack   = 1'b0;
    int unsigned exp_drops = 0;
    int          n_pass    = 0;
    int          n_fail    = 0;
    int          n_total   = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit eligible(input brlite_in_t p);
        return (p.service == BR_SVC_ALL) || (p.service == BR_SVC_TGT && p.target == ADDR);
    endfunction

    function automatic brlite_svc_t to_svc(input brlite_in_t p);
        brlite_svc_t s;
        s.ksvc       = p.ksvc;
        s.seq_source = p.seq_source;
        s.producer   = p.producer;
        s.payload    = p.payload;
        return s;
    endfunction

    function automatic brlite_in_t mk(input brlite_service_t sv, input logic [7:0] k,
                                      input logic [15:0] tgt, input logic [31:0] pl);
        brlite_in_t p;
        p.service    = sv;
        p.ksvc       = k;
        p.seq_source = 16'($urandom);
        p.target     = tgt;
        p.producer   = 16'($urandom);
        p.payload    = pl;
        return p;
    endfunction

    function automatic brlite_in_t rand_pkt();
        int unsigned r = $urandom_range(0, 9);
        brlite_service_t sv = (r < 5) ? BR_SVC_ALL : (r < 8) ? BR_SVC_TGT : BR_SVC_MON;
        logic [15:0] tgt = ($urandom_range(0, 1) == 0) ? ADDR : 16'($urandom_range(1, 65535));
        return mk(sv, 8'($urandom), tgt, $urandom);
    endfunction

    // One clock of the reference: decide acceptance/pop from the current inputs, then check outputs.
    task automatic cycle();
        bit full = (exp_q.size() == DEPTH);
        bit acc;
        bit elig = eligible(br_data);
`ifdef BRLITE_SVC_DROP_EN
        acc = br_rx && !exp_ack;
`else
        acc = br_rx && !exp_ack && (!elig || !full);
`endif
        if (svc_ack && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc && elig) begin
            if (!full) exp_q.push_back(to_svc(br_data));
            else if (exp_drops < 65535) exp_drops++;
        end
        exp_ack = acc;
        @(posedge clk);
        #1;
        chk("ack", 96'(br_ack), 96'(exp_ack));
        chk("svc_rx", 96'(svc_rx), 96'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("head", 96'(svc_data), 96'(exp_q[0]));
`ifdef BRLITE_SVC_DROP_EN
        chk("drop_cnt", 96'(drop_cnt), 96'(exp_drops));
`endif
    endtask

    task automatic send_wait(input brlite_in_t p, input int budget, output bit got);
        br_data = p;
        br_rx   = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (br_ack === 1'b1) got = 1'b1;
        end
    endtask

    task automatic send(input string tag, input brlite_in_t p);
        bit got;
        send_wait(p, 4, got);
        chk(tag, 96'(got), 96'(1'b1));
        br_rx = 1'b0;
        cycle();
    endtask

    task automatic pop();
        svc_ack = 1'b1;
        cycle();
        svc_ack = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            if (exp_q.size() > 0) pop();
        end
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ack   = 1'b0;
        exp_drops = 0;
        chk({tag, "_ack"}, 96'(br_ack), 96'(1'b0));
        chk({tag, "_rx"}, 96'(svc_rx), 96'(1'b0));
        chk({tag, "_data"}, 96'(svc_data), 96'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        brlite_in_t p;
        bit got;

        @(posedge clk);
        #1;
        reset_now("reset");

        // Broadcast service: ack one cycle after accept, entry visible with latency 1
        p = mk(BR_SVC_ALL, 8'h21, 16'h0000, 32'h0000_CAFE);
        send_wait(p, 1, got);
        chk("all_ack_next", 96'(got), 96'(1'b1));
        chk("all_rx", 96'(svc_rx), 96'(1'b1));
        chk("all_data", 96'(svc_data), 96'(to_svc(p)));
        br_rx = 1'b0;
        cycle();
        chk("all_ack_one_cycle", 96'(br_ack), 96'(1'b0));
        pop();

        // Targeted to another PE: acked and discarded
        send("tgt_other_ack", mk(BR_SVC_TGT, 8'h33, 16'h0101, 32'h1234));
        chk("tgt_other_rx", 96'(svc_rx), 96'(1'b0));
        send("mon_ack", mk(BR_SVC_MON, 8'h44, 16'h0000, 32'h5555));
        chk("mon_rx", 96'(svc_rx), 96'(1'b0));
        send("tgt_self_ack", mk(BR_SVC_TGT, 8'h55, ADDR, 32'hBEEF));
        chk("tgt_self_rx", 96'(svc_rx), 96'(1'b1));
        drain();

        // Fill back-to-back with the router holding br_rx high
        for (int k = 0; k < int'(DEPTH); k++) begin
            send_wait(mk(BR_SVC_ALL, 8'(k), 16'h0, 32'h100 + 32'(k)), 4, got);
            chk("fill_ack", 96'(got), 96'(1'b1));
        end
`ifdef BRLITE_SVC_DROP_EN
        for (int k = 0; k < 3; k++) begin
            send_wait(mk(BR_SVC_ALL, 8'hD0 + 8'(k), 16'h0, 32'hDEAD), 4, got);
            chk("drop_ack", 96'(got), 96'(1'b1));
        end
        br_rx = 1'b0;
        cycle();
        chk("drop_cnt3", 96'(drop_cnt), 96'(16'd3));
`else
        p = mk(BR_SVC_ALL, 8'h99, 16'h0, 32'h0999);
        send_wait(p, 6, got);
        chk("full_held", 96'(got), 96'(1'b0));
        svc_ack = 1'b1;
        cycle();
        svc_ack = 1'b0;
        send_wait(p, 4, got);
        chk("held_acked_after_pop", 96'(got), 96'(1'b1));
        br_rx = 1'b0;
        cycle();
`endif
        for (int k = 0; k < int'(DEPTH) - 3; k++) pop();

        // Push and pop in the same cycle at occupancy 3 (pointers have wrapped by now)
        chk("pp_pre_size", 96'(exp_q.size()), 96'(3));
        br_data = mk(BR_SVC_ALL, 8'hEE, 16'h0, 32'hFACE);
        br_rx   = 1'b1;
        svc_ack = 1'b1;
        cycle();
        svc_ack = 1'b0;
        chk("pp_ack", 96'(br_ack), 96'(1'b1));
        br_rx = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            chk("pp_nonempty", 96'(svc_rx), 96'(1'b1));
            pop();
        end
        chk("pp_count3_empty", 96'(svc_rx), 96'(1'b0));

        // Pop on empty is ignored
        pop();
        chk("empty_pop_rx", 96'(svc_rx), 96'(1'b0));
        p = mk(BR_SVC_ALL, 8'h77, 16'h0, 32'h7777);
        send("after_empty_pop", p);
        chk("after_empty_pop_head", 96'(svc_data), 96'(to_svc(p)));
        drain();

        // Reset with 5 entries queued and a packet held by the router
        for (int k = 0; k < 5; k++) send("pre_reset", mk(BR_SVC_ALL, 8'hA0 + 8'(k), 16'h0, $urandom));
        p = mk(BR_SVC_ALL, 8'hBB, 16'h0, 32'hB0B0);
        br_data = p;
        br_rx   = 1'b1;
        reset_now("mid_reset");
        send_wait(p, 2, got);
        chk("reaccept_after_reset", 96'(got), 96'(1'b1));
        chk("reaccept_head", 96'(svc_data), 96'(to_svc(p)));
        br_rx = 1'b0;
        cycle();
        drain();

        // Randomized router / NI traffic
        for (int n = 0; n < 500; n++) begin
            if (br_ack === 1'b1) br_rx = 1'b0;
            if (!br_rx && $urandom_range(0, 2) != 0) begin
                br_data = rand_pkt();
                br_rx   = 1'b1;
            end
            svc_ack = ($urandom_range(0, 3) == 0);
            cycle();
        end
        br_rx   = 1'b0;
        svc_ack = 1'b0;
        cycle();
        drain();
        chk("final_empty", 96'(svc_rx), 96'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/brlite_svc_rx_queue.md
BRLITE_SVC_RX_QUEUE -- requirements
Module: brlite_svc_rx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queued service entries (power of two, >=2).
REQ-002 SHALL have parameter ADDRESS, default 16'b0, local PE address used for target filtering.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port br_rx_i  input  1  router has a valid BrLite packet on br_data_i.
REQ-006 SHALL have port br_ack_o  output  1  one-cycle accept pulse to router.
REQ-007 SHALL have port br_data_i  input  brlite_in_t  service, ksvc, seq_source, target, producer, payload.
REQ-008 SHALL have port br_svc_rx_o  output  1  queue non-empty; feeds NI IRQ/status.
REQ-009 SHALL have port br_svc_ack_i  input  1  one-cycle pop pulse from NI.
REQ-010 SHALL have port br_svc_data_o  output  brlite_svc_t  head entry: ksvc, seq_source, producer, payload.

Function
REQ-011 SHALL accept a packet when br_rx_i=1, br_ack_o=0 and (queue not full or packet is discarded).
REQ-012 SHALL assert br_ack_o the cycle after acceptance, for exactly one cycle; router data is held until the ack is seen.
REQ-013 SHALL never accept while br_ack_o=1 (no double-accept of a held packet).
REQ-014 SHALL enqueue accepted packets with service BR_SVC_ALL, or BR_SVC_TGT with target==ADDRESS.
REQ-015 SHALL discard (ack, no enqueue) BR_SVC_TGT with target!=ADDRESS, and BR_SVC_MON (owned by monitor).
REQ-016 SHALL apply backpressure when full: no ack, no write, br_rx_i held by router.
REQ-017 SHALL drive br_svc_rx_o = (count!=0) combinationally from registered count.
REQ-018 SHALL present the head entry on br_svc_data_o while non-empty; value undefined-but-stable ('0 after reset) when empty.
REQ-019 SHALL pop one entry per br_svc_ack_i pulse; pop on empty SHALL be ignored.
REQ-020 SHALL handle simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-021 SHALL treat full as count==DEPTH; a pop in the same cycle does not enable a push (no same-cycle full bypass).
REQ-022 SHALL use log2(DEPTH)-bit pointers wrapping modulo DEPTH and a log2(DEPTH)+1-bit count.
REQ-023 SHALL make a pushed entry visible on br_svc_rx_o one cycle after the accept edge (latency 1).

Reset
REQ-024 SHALL on rst_ni=0 clear pointers, count, br_ack_o, br_svc_data_o storage head, drop counter.
REQ-025 SHALL discard queue contents on reset mid-operation; a packet held by the router is re-accepted after reset release.

Configuration
REQ-026 SHALL, with BRLITE_SVC_DROP_EN defined, ack and discard enqueue-eligible packets when full instead of backpressure.
REQ-027 SHALL, with BRLITE_SVC_DROP_EN defined, add port br_svc_drop_cnt_o output 16, saturating count of full-drops.
REQ-028 SHALL, without BRLITE_SVC_DROP_EN, apply REQ-016 and omit br_svc_drop_cnt_o.

Structure
REQ-029 SHALL place brlite_in_t, brlite_service_t (BR_SVC_ALL, BR_SVC_TGT, BR_SVC_MON) and BRLITE_SVC_DEPTH in DMNIPkg alongside brlite_svc_t.
REQ-030 SHALL use one sub-module brlite_svc_fifo (storage, pointers, count); filtering and handshake stay in the top.

Verification
REQ-031 SHALL cover: BR_SVC_ALL ksvc=8'h21 payload=32'hCAFE -> ack pulse 1 cycle, br_svc_rx_o=1 next cycle, data matches.
REQ-032 SHALL cover: BR_SVC_TGT target=16'h0101, ADDRESS=16'h0000 -> ack, br_svc_rx_o stays 0.
REQ-033 SHALL cover: 9 packets back-to-back, DEPTH=8, no pops -> 8 acks, 9th held without ack until one pop, then acked.
REQ-034 SHALL cover: push and pop same cycle at count=3 -> count stays 3, FIFO order preserved across wrap.
REQ-035 SHALL cover: pop pulse on empty -> count stays 0, no pointer change; reset mid-stream with 5 entries -> br_svc_rx_o=0.
REQ-036 SHALL cover (BRLITE_SVC_DROP_EN): full queue plus 3 packets -> 3 acks, br_svc_drop_cnt_o=3, contents unchanged.
